// File: rtl/rat_intr_pkg.sv
// Shared definitions for the interrupt controller: FSM states, I/O port offsets
// and the number of interrupt sources.
package rat_intr_pkg;

    localparam int NUM_IRQ = 8;
    localparam int VEC_W   = $clog2(NUM_IRQ);

    localparam logic [7:0] MASK_OFS = 8'd0;
    localparam logic [7:0] PEND_OFS = 8'd1;
    localparam logic [7:0] VEC_OFS  = 8'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intr_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit two-flop synchronizer followed by a third flop that turns a
// synchronized low-to-high transition into a one-cycle pulse.
module irq_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/intr_ctrl.sv
// Prioritised, non-nesting interrupt controller with MCU-visible mask, pending
// (write-1-to-clear) and vector ports.
module intr_ctrl
    import rat_intr_pkg::*;
#(
    parameter logic [7:0] BASE_PORT = 8'h30
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               io_strb,
    output logic [7:0]         in_port,
    output logic               int_req,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic [VEC_W-1:0]   vector
);

    localparam logic [7:0] MASK_ADDR = BASE_PORT + MASK_OFS;
    localparam logic [7:0] PEND_ADDR = BASE_PORT + PEND_OFS;
    localparam logic [7:0] VEC_ADDR  = BASE_PORT + VEC_OFS;

    intr_state_t        state;
    intr_state_t        state_nxt;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] pend_nxt;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] armed;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] sw_clr;
    logic [VEC_W-1:0]   first_idx;
    logic [VEC_W-1:0]   vector_nxt;
    logic               int_req_nxt;

    irq_sync_edge #(.WIDTH(NUM_IRQ)) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (irq),
        .rise     (rise)
    );

    assign armed = pend & mask;

    // Bit 0 has the highest priority, so scan downwards and keep the last hit.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (armed[i]) first_idx = VEC_W'(i);
        end
    end

    always_comb begin
        state_nxt   = state;
        vector_nxt  = vector;
        int_req_nxt = 1'b0;
        ack_clr     = '0;
        case (state)
            IDLE: begin
                if (|armed) begin
                    state_nxt   = REQ;
                    vector_nxt  = first_idx;
                    int_req_nxt = 1'b1;
                end
            end
            REQ: begin
                int_req_nxt = 1'b1;
                if (int_ack) begin
                    state_nxt        = SERVICE;
                    int_req_nxt      = 1'b0;
                    ack_clr[vector]  = 1'b1;
                end
            end
            SERVICE: begin
                if (int_eoi) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A fresh edge overrides any clear aimed at the same bit in this cycle.
    assign sw_clr   = (io_strb && port_id == PEND_ADDR) ? out_port : '0;
    assign pend_nxt = (pend & ~(sw_clr | ack_clr)) | rise;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            mask    <= '0;
            pend    <= '0;
            vector  <= '0;
            int_req <= 1'b0;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            vector  <= vector_nxt;
            int_req <= int_req_nxt;
            if (io_strb && port_id == MASK_ADDR) mask <= out_port;
        end
    end

    always_comb begin
        in_port = '0;
        if (port_id == MASK_ADDR)      in_port = mask;
        else if (port_id == PEND_ADDR) in_port = pend;
        else if (port_id == VEC_ADDR)  in_port = {{(8 - VEC_W){1'b0}}, vector};
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus random traffic,
// all judged against a behavioural model of the controller's rules.
module tb_intr_ctrl;

    localparam logic [7:0] BASE = 8'h30;
    localparam logic [7:0] A_MASK = BASE;
    localparam logic [7:0] A_PEND = BASE + 8'd1;
    localparam logic [7:0] A_VEC  = BASE + 8'd2;

    logic       clk;
    logic       reset_n;
    logic [7:0] irq;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;
    logic [7:0] in_port;
    logic       int_req;
    logic       int_ack;
    logic       int_eoi;
    logic [2:0] vector;

    int nCompared;
    int nMismatched;

    // Reference model: register-level view of what the MCU can observe.
    logic [7:0] mMask;
    logic [7:0] mPend;
    logic [2:0] mVec;
    logic       mReq;
    int         mMode;
    logic [7:0] mSeen [3];

    intr_ctrl #(.BASE_PORT(BASE)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .irq      (irq),
        .port_id  (port_id),
        .out_port (out_port),
        .io_strb  (io_strb),
        .in_port  (in_port),
        .int_req  (int_req),
        .int_ack  (int_ack),
        .int_eoi  (int_eoi),
        .vector   (vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %02h expected %02h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [7:0] expRead(input logic [7:0] pid);
        if (pid == A_MASK) return mMask;
        if (pid == A_PEND) return mPend;
        if (pid == A_VEC)  return {5'b0, mVec};
        return 8'h00;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic modelEdge();
        logic [7:0] rose;
        logic [7:0] clr;
        logic [7:0] ready;
        int         nextMode;
        if (!reset_n) begin
            mMask = 0; mPend = 0; mVec = 0; mReq = 0; mMode = 0;
            for (int k = 0; k < 3; k++) mSeen[k] = 0;
            return;
        end
        rose = mSeen[1] & ~mSeen[2];
        clr = (io_strb && port_id == A_PEND) ? out_port : 8'h00;
        ready = mPend & mMask;
        nextMode = mMode;
        if (mMode == 0 && ready != 0) begin
            nextMode = 1;
            for (int k = 7; k >= 0; k--) if (ready[k]) mVec = 3'(k);
        end else if (mMode == 1 && int_ack) begin
            clr = clr | (8'd1 << mVec);
            nextMode = 2;
        end else if (mMode == 2 && int_eoi) begin
            nextMode = 0;
        end
        mPend = (mPend & ~clr) | rose;
        if (io_strb && port_id == A_MASK) mMask = out_port;
        mSeen[2] = mSeen[1];
        mSeen[1] = mSeen[0];
        mSeen[0] = irq;
        mMode = nextMode;
        mReq = (nextMode == 1);
    endtask

    task automatic applyStimulus(input logic rn, input logic [7:0] irqV, input logic [7:0] pid,
                                 input logic [7:0] data, input logic strb, input logic ack, input logic eoi);
        reset_n = rn; irq = irqV; port_id = pid; out_port = data;
        io_strb = strb; int_ack = ack; int_eoi = eoi;
        #1;
        checkOutput("in_port", in_port, expRead(pid));
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("int_req", {7'b0, int_req}, {7'b0, mReq});
        checkOutput("vector", {5'b0, vector}, {5'b0, mVec});
    endtask

    task automatic peek(input logic [7:0] pid, input string tag, input logic [7:0] expected);
        port_id = pid;
        #1;
        checkOutput(tag, in_port, expected);
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        reset_n = 0; irq = 0; port_id = 0; out_port = 0; io_strb = 0; int_ack = 0; int_eoi = 0;
        mMask = 0; mPend = 0; mVec = 0; mReq = 0; mMode = 0;
        for (int k = 0; k < 3; k++) mSeen[k] = 0;

        applyStimulus(0, 8'h00, A_MASK, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, A_MASK, 8'h00, 0, 0, 0);
        checkOutput("reset_int_req", {7'b0, int_req}, 8'h00);
        peek(A_MASK, "reset_mask", 8'h00);
        peek(A_PEND, "reset_pend", 8'h00);

        // Single source: edge, pend after three edges, request, acknowledge.
        applyStimulus(1, 8'h00, A_MASK, 8'h04, 1, 0, 0);
        applyStimulus(1, 8'h04, A_PEND, 8'h00, 0, 0, 0);
        applyStimulus(1, 8'h00, A_PEND, 8'h00, 0, 0, 0);
        applyStimulus(1, 8'h00, A_PEND, 8'h00, 0, 0, 0);
        peek(A_PEND, "single_pend", 8'h04);
        checkOutput("single_req_low", {7'b0, int_req}, 8'h00);
        applyStimulus(1, 8'h00, A_VEC, 8'h00, 0, 0, 0);
        checkOutput("single_req_high", {7'b0, int_req}, 8'h01);
        peek(A_VEC, "single_vec", 8'h02);
        applyStimulus(1, 8'h00, A_PEND, 8'h00, 0, 1, 0);
        checkOutput("single_ack_req", {7'b0, int_req}, 8'h00);
        peek(A_PEND, "single_ack_pend", 8'h00);
        applyStimulus(1, 8'h00, A_PEND, 8'h00, 0, 0, 1);

        // Set beats clear: edge on irq[4] arrives in the cycle of a PEND write.
        applyStimulus(1, 8'h00, A_MASK, 8'h00, 1, 0, 0);
        applyStimulus(1, 8'h10, A_PEND, 8'h00, 0, 0, 0);
        applyStimulus(1, 8'h00, A_PEND, 8'h00, 0, 0, 0);
        applyStimulus(1, 8'h00, A_PEND, 8'h10, 1, 0, 0);
        peek(A_PEND, "set_wins", 8'h10);
        applyStimulus(1, 8'h00, A_PEND, 8'h10, 1, 0, 0);
        peek(A_PEND, "w1c", 8'h00);

        for (int c = 0; c < 3000; c++) begin
            logic [7:0] pid;
            logic [7:0] nextIrq;
            case ($urandom_range(0, 4))
                0: pid = A_MASK;
                1, 2: pid = A_PEND;
                3: pid = A_VEC;
                default: pid = 8'($urandom);
            endcase
            nextIrq = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            applyStimulus($urandom_range(0, 99) != 0, nextIrq, pid,
                          (pid == A_MASK) ? 8'($urandom) | 8'h01 : 8'($urandom),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
